fft_sample_buffer: RTL
======================

# fft_sample_buffer

Parametrised complex-sample buffer for the FFT accuracy bench. A host writes a frame of DEPTH complex samples by address. On `start` the block streams the frame out in natural or bit-reversed order over a valid/ready handshake. While streaming it flags samples whose magnitude exceeds a programmable limit. It sits between the stimulus loader and the FFT core / checker, and replaces the fixed 256×16-bit, no-backpressure buffer.

## Interface
- `DATA_W`, 16: width of each signed real/imag component.
- `DEPTH`, 256: frame length; power of two, ≥ 4.
- `ADDR_W`, $clog2(DEPTH): address width (derived, not overridden).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: write strobe for the sample memory.
- `wr_addr` in ADDR_W: write address.
- `wr_real`, `wr_imag` in DATA_W: signed sample to write.
- `start` in 1: single-cycle pulse that begins readout.
- `bitrev` in 1: readout order, 0 = natural, 1 = bit-reversed; sampled on accepted `start`.
- `max_mag` in DATA_W-1: unsigned magnitude limit; sampled on accepted `start`.
- `out_valid` out 1: output sample valid.
- `out_ready` in 1: downstream accepts the sample.
- `out_real`, `out_imag` out DATA_W: output sample.
- `out_index` out ADDR_W: sequence number (0..DEPTH-1) of the current output.
- `out_addr` out ADDR_W: memory address of the current output.
- `out_ovf` out 1: current sample exceeds `max_mag`.
- `busy` out 1: frame readout in progress.
- `done` out 1: one-cycle pulse after the last transfer.
- `error_flag` out 1: sticky error, cleared on accepted `start`.
- `ovf_count` out ADDR_W+1: number of transferred samples with `out_ovf`=1 in this frame.

## Operation
- FSM states:
  - IDLE: `busy`=0. Accepted `start` → READ.
  - READ: `busy`=1, `out_valid`=1. Transfer on `out_valid && out_ready`. The transfer of index DEPTH-1 → DONE.
  - DONE: `done`=1, `busy`=0. → IDLE unconditionally.
- Writes:
  - Performed only in IDLE with `start`=0.
  - A `wr_en` in any other cycle, including the same cycle as an accepted `start`, is dropped and sets `error_flag`.
- `start` is accepted only in IDLE. In READ or DONE it is ignored, with no error.
- Accepted `start` does all of the following:
  - clears `error_flag` and `ovf_count`;
  - latches `bitrev` and `max_mag`;
  - loads sequence counter i=0.
- Address mapping: `out_addr` = i when bitrev=0; otherwise `out_addr` = i with its ADDR_W bits reversed.
- Overflow test: `out_ovf` = (|out_real| > max_mag) OR (|out_imag| > max_mag).
  - |x| is computed at DATA_W+1 bits, so the most negative value never wraps.
  - A transfer with `out_ovf`=1 increments `ovf_count` and sets `error_flag`.
  - `ovf_count` saturates at DEPTH.
- Stall: while `out_ready`=0, all `out_*` outputs hold stable.
- Memory content persists across frames and is not cleared by `rst`.

## Timing
- Reset values:
  - FSM = IDLE;
  - `out_valid`, `busy`, `done`, `error_flag`, `out_ovf` = 0;
  - `out_real`, `out_imag`, `out_index`, `out_addr`, `ovf_count` = 0.
- Write latency: data written at edge N is readable by a `start` accepted at edge N+1 or later.
- Start latency: `start` high at edge N gives, from edge N+1, `out_valid`=1 with sample index 0 registered.
- Throughput: one sample per cycle with `out_ready` held high.
  - Frame = DEPTH cycles in READ, then `done` at cycle N+DEPTH+1.
- Output registers load the next sample on the same edge as a transfer. The memory read is therefore combinational, or synchronous with a lookahead address (i+1 on transfer).
- `rst` mid-frame: on the next edge, return to IDLE with reset values. Any partially streamed frame is abandoned.
- `start` in the DONE cycle is ignored. The earliest restart is the first IDLE cycle.

## Structure
- Package `fft_buf_pkg`:
  - FSM state enum (IDLE/READ/DONE);
  - `bitrev_f` function (ADDR_W-generic reversal);
  - `cplx_t` struct-style typedef of real/imag.
- Sub-module `fft_bitrev_addr`: purely combinational index→address map, selected by latched `bitrev`. Reused by the FFT core.
- Memory: two DATA_W×DEPTH arrays or one packed 2·DATA_W array, inferred.

## Test plan
- Natural order: write x[k]=k (imag = −k) for DEPTH=256, `start` with bitrev=0, ready high → indices 0..255 in order with real=k, `done` at cycle 257 after start, `ovf_count`=0.
- Bit-reversed order: same data, bitrev=1, DEPTH=8 → `out_addr` sequence 0,4,2,6,1,5,3,7.
- Backpressure: toggle `out_ready` randomly at 50% → outputs hold while ready=0, no sample lost or duplicated, 256 transfers total.
- Overflow: max_mag=1000 with samples 1001, −1001, 1000 and −32768 → `out_ovf` on the 1st, 2nd and 4th; `ovf_count`=3; `error_flag`=1; next `start` clears both.
- Write during READ, and `wr_en` coincident with `start` → writes dropped, memory unchanged on the next frame, `error_flag`=1.
- `rst` asserted at transfer 100 → next cycle `busy`=0, `out_valid`=0; a new `start` restreams from index 0 with the old memory contents.

Source files
------------

// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT sample buffer and the FFT core.
package fft_buf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    // Reverses the low w bits of a; bits at and above w come back as zero.
    function automatic logic [31:0] bitrev_f(input logic [31:0] a, input int unsigned w);
        logic [31:0] r;
        r = '0;
        for (int unsigned b = 0; b < 32; b++)
            if (b < w) r[w-1-b] = a[b];
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Combinational sequence-index to memory-address map (natural or bit-reversed).
module fft_bitrev_addr
    import fft_buf_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] idx,
    input  logic              rev,
    output logic [ADDR_W-1:0] addr
);

    assign addr = rev ? ADDR_W'(bitrev_f(32'(idx), ADDR_W)) : idx;

endmodule

// File: rtl/fft_sample_buffer.sv
// Complex frame buffer: host writes by address, streams out natural or
// bit-reversed over valid/ready, flagging samples above a magnitude limit.
module fft_sample_buffer
    import fft_buf_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_real,
    input  logic [DATA_W-1:0] wr_imag,
    input  logic              start,
    input  logic              bitrev,
    input  logic [DATA_W-2:0] max_mag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [ADDR_W-1:0] out_index,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_ovf,
    output logic              busy,
    output logic              done,
    output logic              error_flag,
    output logic [ADDR_W:0]   ovf_count
);

    state_t            state;
    logic              bitrev_q;
    logic [DATA_W-2:0] max_mag_q;

    logic [DATA_W-1:0] mem_re [DEPTH];
    logic [DATA_W-1:0] mem_im [DEPTH];

    logic              start_acc, wr_ok, xfer, last, err_set;
    logic [ADDR_W-1:0] nxt_idx, nxt_addr;
    logic [DATA_W-1:0] rd_re, rd_im;
    logic [DATA_W-2:0] limit;
    logic [DATA_W:0]   ext_re, ext_im, abs_re, abs_im;
    logic              ovf_nxt;

    assign start_acc = start && (state == ST_IDLE);
    assign wr_ok     = (state == ST_IDLE) && !start;
    assign xfer      = (state == ST_READ) && out_ready;
    assign last      = (out_index == ADDR_W'(DEPTH-1));
    assign err_set   = (wr_en && !wr_ok) || (xfer && out_ovf);

    assign out_valid = (state == ST_READ);
    assign busy      = (state == ST_READ);
    assign done      = (state == ST_DONE);

    // Index 0 maps to address 0 in both orders, so the stale bitrev_q on
    // the start cycle is harmless.
    assign nxt_idx = start_acc ? '0 : out_index + 1'b1;

    fft_bitrev_addr #(.ADDR_W(ADDR_W)) u_addr (
        .idx  (nxt_idx),
        .rev  (bitrev_q),
        .addr (nxt_addr)
    );

    // Combinational read so the output registers load the next sample on
    // the same edge as the transfer.
    assign rd_re = mem_re[nxt_addr];
    assign rd_im = mem_im[nxt_addr];
    assign limit = start_acc ? max_mag : max_mag_q;

    // Magnitudes at DATA_W+1 bits so the most negative input does not wrap.
    assign ext_re  = {rd_re[DATA_W-1], rd_re};
    assign ext_im  = {rd_im[DATA_W-1], rd_im};
    assign abs_re  = ext_re[DATA_W] ? (~ext_re + 1'b1) : ext_re;
    assign abs_im  = ext_im[DATA_W] ? (~ext_im + 1'b1) : ext_im;
    assign ovf_nxt = (abs_re > {2'b00, limit}) || (abs_im > {2'b00, limit});

    // Memory is deliberately not reset: contents persist across frames.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) begin
            mem_re[wr_addr] <= wr_real;
            mem_im[wr_addr] <= wr_imag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bitrev_q   <= 1'b0;
            max_mag_q  <= '0;
            out_real   <= '0;
            out_imag   <= '0;
            out_index  <= '0;
            out_addr   <= '0;
            out_ovf    <= 1'b0;
            error_flag <= 1'b0;
            ovf_count  <= '0;
        end else begin
            if (start_acc)    error_flag <= err_set;
            else if (err_set) error_flag <= 1'b1;

            if (start_acc || (xfer && !last)) begin
                out_real  <= rd_re;
                out_imag  <= rd_im;
                out_index <= nxt_idx;
                out_addr  <= nxt_addr;
                out_ovf   <= ovf_nxt;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_READ;
                        bitrev_q  <= bitrev;
                        max_mag_q <= max_mag;
                        ovf_count <= '0;
                    end
                end
                ST_READ: begin
                    if (out_ready) begin
                        if (out_ovf && ovf_count != (ADDR_W+1)'(DEPTH))
                            ovf_count <= ovf_count + 1'b1;
                        if (last) state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
